// File: rtl/cheri_stkz_lsu_arb_pkg.sv
// Shared widths and request bundle for the LSU / stack-zeroization arbiter.
package cheri_stkz_lsu_arb_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 33;  // 32 data bits + tag in the MSB
  localparam int unsigned BE_W   = 4;

  localparam logic [BE_W-1:0] STKZ_BE = 4'hf;

  typedef struct packed {
    logic              we;
    logic              is_cap;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } lsu_req_t;
endpackage

// File: rtl/cheri_stkz_lsu_arb_if.sv
// Core load/store port as seen by the arbiter; slave is the arbiter side.
interface cheri_stkz_lsu_arb_if;
  import cheri_stkz_lsu_arb_pkg::*;

  logic              core_req_i;
  logic              core_we_i;
  logic              core_is_cap_i;
  logic [BE_W-1:0]   core_be_i;
  logic [ADDR_W-1:0] core_addr_i;
  logic [DATA_W-1:0] core_wdata_i;
  logic              core_gnt_o;
  logic              core_rvalid_o;
  logic              core_err_o;
  logic [DATA_W-1:0] core_rdata_o;

  modport master (
    output core_req_i, core_we_i, core_is_cap_i, core_be_i, core_addr_i, core_wdata_i,
    input  core_gnt_o, core_rvalid_o, core_err_o, core_rdata_o
  );

  modport slave (
    input  core_req_i, core_we_i, core_is_cap_i, core_be_i, core_addr_i, core_wdata_i,
    output core_gnt_o, core_rvalid_o, core_err_o, core_rdata_o
  );
endinterface

// File: rtl/cheri_stkz_lsu_arb.sv
// Single-outstanding data-port arbiter: core has priority, stkz zero-writes
// fill idle slots, responses are routed back to whoever issued.
module cheri_stkz_lsu_arb
  import cheri_stkz_lsu_arb_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  cheri_stkz_lsu_arb_if.slave core,
  input  logic              stkz_req_i,
  input  logic              stkz_we_i,
  input  logic              stkz_is_cap_i,
  input  logic [ADDR_W-1:0] stkz_addr_i,
  input  logic [DATA_W-1:0] stkz_wdata_i,
  input  logic              stkz_abort_i,
  output logic              stkz_req_done_o,
  output logic              stkz_resp_valid_o,
  output logic              stkz_resp_err_o,
  output logic              data_req_o,
  output logic              data_we_o,
  output logic              data_is_cap_o,
  output logic [BE_W-1:0]   data_be_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic              data_err_i,
  input  logic [DATA_W-1:0] data_rdata_i
);
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_REQ  = 2'd1;
  localparam logic [1:0] ARB_RESP = 2'd2;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_STKZ = 1'b1;

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       sel_own, idle, stkz_win, drain, issue, resp_fire;
  lsu_req_t   core_r, stkz_r, sel_r;

  assign core_r = '{we: core.core_we_i, is_cap: core.core_is_cap_i, be: core.core_be_i,
                    addr: core.core_addr_i, wdata: core.core_wdata_i};
  assign stkz_r = '{we: stkz_we_i, is_cap: stkz_is_cap_i, be: STKZ_BE,
                    addr: stkz_addr_i, wdata: stkz_wdata_i};

  assign idle     = (state_q == ARB_IDLE);
  assign stkz_win = ~core.core_req_i & stkz_req_i & ~stkz_abort_i;
  assign drain    = idle & ~core.core_req_i & stkz_req_i & stkz_abort_i;
  assign sel_own  = idle ? (core.core_req_i ? OWN_CORE : OWN_STKZ) : owner_q;
  assign sel_r    = (sel_own == OWN_CORE) ? core_r : stkz_r;

  // Every output is gated by rst_ni so nothing leaks while reset is asserted,
  // including the combinational IDLE issue path.
  assign issue     = rst_ni & ((idle & (core.core_req_i | stkz_win)) | (state_q == ARB_REQ));
  assign resp_fire = rst_ni & (state_q == ARB_RESP) & data_rvalid_i;

  assign data_req_o    = issue;
  assign data_we_o     = issue & sel_r.we;
  assign data_is_cap_o = issue & sel_r.is_cap;
  assign data_be_o     = issue ? sel_r.be    : '0;
  assign data_addr_o   = issue ? sel_r.addr  : '0;
  assign data_wdata_o  = issue ? sel_r.wdata : '0;

  assign core.core_gnt_o    = data_gnt_i & issue & (sel_own == OWN_CORE);
  assign core.core_rvalid_o = resp_fire & (owner_q == OWN_CORE);
  assign core.core_err_o    = core.core_rvalid_o & data_err_i;
  assign core.core_rdata_o  = core.core_rvalid_o ? data_rdata_i : '0;

  assign stkz_resp_valid_o = resp_fire & (owner_q == OWN_STKZ);
  assign stkz_resp_err_o   = stkz_resp_valid_o & data_err_i;
  assign stkz_req_done_o   = stkz_resp_valid_o | (rst_ni & drain);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (core.core_req_i | stkz_win) begin
          owner_d = sel_own;
          state_d = data_gnt_i ? ARB_RESP : ARB_REQ;
        end
      end
      // Once offered, the request stays up regardless of abort or core demand.
      ARB_REQ:  if (data_gnt_i)    state_d = ARB_RESP;
      ARB_RESP: if (data_rvalid_i) state_d = ARB_IDLE;
      default:                     state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_CORE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  a_rvalid_only_in_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    data_rvalid_i |-> (state_q == ARB_RESP));
endmodule

// File: tb/tb_cheri_stkz_lsu_arb.sv
// Directed scenarios plus randomized core/stkz/memory traffic checked every
// cycle against a transaction-queue model of the arbitration rules.
module tb_cheri_stkz_lsu_arb;
  import cheri_stkz_lsu_arb_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              stkz_req_i, stkz_we_i, stkz_is_cap_i, stkz_abort_i;
  logic [ADDR_W-1:0] stkz_addr_i;
  logic [DATA_W-1:0] stkz_wdata_i;
  logic              stkz_req_done_o, stkz_resp_valid_o, stkz_resp_err_o;
  logic              data_req_o, data_we_o, data_is_cap_o;
  logic [BE_W-1:0]   data_be_o;
  logic [ADDR_W-1:0] data_addr_o;
  logic [DATA_W-1:0] data_wdata_o;
  logic              data_gnt_i, data_rvalid_i, data_err_i;
  logic [DATA_W-1:0] data_rdata_i;

  int tests = 0;
  int fails = 0;

  cheri_stkz_lsu_arb_if cif ();

  cheri_stkz_lsu_arb dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .core(cif),
    .stkz_req_i(stkz_req_i), .stkz_we_i(stkz_we_i), .stkz_is_cap_i(stkz_is_cap_i),
    .stkz_addr_i(stkz_addr_i), .stkz_wdata_i(stkz_wdata_i), .stkz_abort_i(stkz_abort_i),
    .stkz_req_done_o(stkz_req_done_o), .stkz_resp_valid_o(stkz_resp_valid_o),
    .stkz_resp_err_o(stkz_resp_err_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_is_cap_o(data_is_cap_o),
    .data_be_o(data_be_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
    .data_rdata_i(data_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic              own;   // 1 = stkz
    logic              we;
    logic              cap;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  txn_t m_q[$];        // accepted by memory, waiting for its response
  bit   m_offer = 0;   // a request is on the bus but not yet accepted
  txn_t m_bus;

  always @(negedge clk_i) begin
    txn_t t;
    bit   have;
    logic e_req, e_cg, e_crv, e_cerr, e_done, e_srv, e_serr;
    logic [DATA_W-1:0] e_crd;
    e_req = 0; e_cg = 0; e_crv = 0; e_cerr = 0; e_done = 0; e_srv = 0; e_serr = 0;
    e_crd = '0; have = 0; t = '0;
    if (!rst_ni) begin
      m_q.delete();
      m_offer = 0;
    end else if (m_q.size() > 0) begin
      if (data_rvalid_i) begin
        t = m_q.pop_front();
        if (t.own) begin e_srv = 1; e_serr = data_err_i; e_done = 1; end
        else       begin e_crv = 1; e_cerr = data_err_i; e_crd = data_rdata_i; end
      end
    end else begin
      if (m_offer) begin
        t = m_bus; have = 1;
      end else if (cif.core_req_i) begin
        t = '{own: 1'b0, we: cif.core_we_i, cap: cif.core_is_cap_i, be: cif.core_be_i,
              addr: cif.core_addr_i, wdata: cif.core_wdata_i};
        have = 1;
      end else if (stkz_req_i && !stkz_abort_i) begin
        t = '{own: 1'b1, we: stkz_we_i, cap: stkz_is_cap_i, be: 4'hf,
              addr: stkz_addr_i, wdata: stkz_wdata_i};
        have = 1;
      end else if (stkz_req_i && stkz_abort_i) begin
        e_done = 1;
      end
      if (have) begin
        e_req = 1;
        e_cg  = data_gnt_i && !t.own;
        if (data_gnt_i) begin m_q.push_back(t); m_offer = 0; end
        else            begin m_bus = t; m_offer = 1; end
      end
    end
    chk("cycle_ctl",
        {data_req_o, cif.core_gnt_o, cif.core_rvalid_o, cif.core_err_o, cif.core_rdata_o,
         stkz_req_done_o, stkz_resp_valid_o, stkz_resp_err_o},
        {e_req, e_cg, e_crv, e_cerr, e_crd, e_done, e_srv, e_serr});
    if (e_req)
      chk("cycle_bus",
          {data_we_o, data_is_cap_o, data_be_o, data_addr_o, data_wdata_o},
          {t.we, t.cap, t.be, t.addr, t.wdata});
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    cif.core_req_i = 0; cif.core_we_i = 0; cif.core_is_cap_i = 0; cif.core_be_i = '0;
    cif.core_addr_i = '0; cif.core_wdata_i = '0;
    stkz_req_i = 0; stkz_we_i = 1; stkz_is_cap_i = 0; stkz_abort_i = 0;
    stkz_addr_i = '0; stkz_wdata_i = '0;
    data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0; data_rdata_i = '0;
  endtask

  task automatic set_core(input logic we, input logic [3:0] be, input logic [31:0] a,
                          input logic [32:0] wd);
    cif.core_req_i = 1; cif.core_we_i = we; cif.core_is_cap_i = 0;
    cif.core_be_i = be; cif.core_addr_i = a; cif.core_wdata_i = wd;
  endtask

  logic [127:0] all_out;
  assign all_out = {data_req_o, data_we_o, data_is_cap_o, data_be_o, data_addr_o, data_wdata_o,
                    cif.core_gnt_o, cif.core_rvalid_o, cif.core_err_o, cif.core_rdata_o,
                    stkz_req_done_o, stkz_resp_valid_o, stkz_resp_err_o};

  initial begin
    bit acc, cg, dn, waiting;
    int lat;
    logic [31:0] saddr;
    idle_inputs();
    rst_ni = 0;
    // Reset with live inputs: everything must stay quiet.
    set_core(1'b1, 4'hf, 32'h40, 33'h1_0000_0001);
    stkz_req_i = 1; data_rvalid_i = 1; data_gnt_i = 1;
    smp(); chk("reset_outputs_zero", all_out, '0);

    // Stkz alone.
    step(); idle_inputs(); rst_ni = 1;
    stkz_req_i = 1; stkz_addr_i = 32'h100; data_gnt_i = 1;
    smp(); chk("stkz_alone_issue", {data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o},
               {1'b1, 1'b1, 4'hf, 32'h100, 33'h0});
    step(); data_gnt_i = 0;
    smp(); chk("stkz_wait_no_req", data_req_o, 1'b0);
    step(); data_rvalid_i = 1;
    smp(); chk("stkz_done_with_resp", {stkz_req_done_o, stkz_resp_valid_o, cif.core_rvalid_o},
               3'b110);
    step(); data_rvalid_i = 0; stkz_addr_i = 32'h104; data_gnt_i = 1;
    smp(); chk("stkz_next_addr", {data_req_o, data_addr_o}, {1'b1, 32'h104});
    step(); data_gnt_i = 0; data_rvalid_i = 1;
    smp();
    step(); data_rvalid_i = 0; stkz_req_i = 0;

    // Collision: core wins, stkz after the bubble.
    set_core(1'b0, 4'hf, 32'h200, '0);
    stkz_req_i = 1; stkz_addr_i = 32'h0FC; data_gnt_i = 1;
    smp(); chk("collision_core_first", {data_addr_o, data_we_o, cif.core_gnt_o},
               {32'h200, 1'b0, 1'b1});
    step(); cif.core_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = 33'h1_DEADBEEF;
    smp(); chk("collision_core_resp",
               {cif.core_rvalid_o, cif.core_rdata_o, stkz_resp_valid_o, data_req_o},
               {1'b1, 33'h1_DEADBEEF, 1'b0, 1'b0});
    step(); data_rvalid_i = 0; data_rdata_i = '0;
    smp(); chk("collision_stkz_after", {data_req_o, data_addr_o, data_be_o},
               {1'b1, 32'h0FC, 4'hf});

    // Delayed gnt with a core request arriving while stkz is held.
    step(); set_core(1'b1, 4'h3, 32'h300, 33'h0_0000_5A5A);
    smp(); chk("delay_gnt_hold1", {data_addr_o, cif.core_gnt_o}, {32'h0FC, 1'b0});
    step();
    smp(); chk("delay_gnt_hold2", {data_req_o, data_addr_o}, {1'b1, 32'h0FC});
    step(); data_gnt_i = 1;
    smp(); chk("delay_gnt_accept", {data_addr_o, cif.core_gnt_o}, {32'h0FC, 1'b0});
    step(); data_gnt_i = 0; data_rvalid_i = 1; data_err_i = 1;
    smp(); chk("stkz_error", {stkz_resp_err_o, stkz_resp_valid_o, stkz_req_done_o, cif.core_err_o},
               4'b1110);
    step(); data_rvalid_i = 0; data_err_i = 0; stkz_req_i = 0; data_gnt_i = 1;
    smp(); chk("core_after_wait", {data_addr_o, data_be_o, cif.core_gnt_o}, {32'h300, 4'h3, 1'b1});
    step(); cif.core_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = 33'h0_12345678;
    smp(); chk("core_read_back", cif.core_rdata_o, 33'h0_12345678);
    step(); data_rvalid_i = 0; data_rdata_i = '0;

    // Abort drain.
    stkz_req_i = 1; stkz_abort_i = 1; stkz_addr_i = 32'h104;
    smp(); chk("drain_pulse", {stkz_req_done_o, data_req_o, stkz_resp_valid_o}, 3'b100);
    step(); stkz_req_i = 0; stkz_abort_i = 0;
    smp(); chk("drain_ends", stkz_req_done_o, 1'b0);

    // Reset while waiting for a response.
    step(); stkz_req_i = 1; stkz_addr_i = 32'h108; data_gnt_i = 1;
    smp();
    step(); data_gnt_i = 0;
    smp();
    step(); rst_ni = 0; data_rvalid_i = 1;
    smp(); chk("reset_in_resp_zero", all_out, '0);
    step(); rst_ni = 1; data_rvalid_i = 0; stkz_req_i = 0;
    smp(); chk("post_reset_idle", {data_req_o, stkz_resp_valid_o, stkz_req_done_o}, 3'b000);
    step(); stkz_req_i = 1; stkz_addr_i = 32'h10C;
    smp(); chk("post_reset_issue", {data_req_o, data_addr_o}, {1'b1, 32'h10C});
    step(); data_gnt_i = 1;
    smp();
    step(); data_gnt_i = 0; data_rvalid_i = 1;
    smp(); chk("post_reset_done", {stkz_req_done_o, stkz_resp_valid_o}, 2'b11);
    step(); data_rvalid_i = 0; stkz_req_i = 0;

    // Randomized traffic; the model process checks every cycle.
    waiting = 0; lat = 0; saddr = 32'h1000;
    stkz_addr_i = saddr;
    for (int c = 0; c < 4000; c++) begin
      smp();
      acc = data_req_o & data_gnt_i;
      cg  = cif.core_gnt_o;
      dn  = stkz_req_done_o;
      step();
      data_rvalid_i = 0; data_err_i = 0; data_rdata_i = '0;
      if (acc) begin waiting = 1; lat = $urandom_range(0, 2); end
      if (waiting) begin
        if (lat == 0) begin
          data_rvalid_i = 1; waiting = 0;
          data_rdata_i = {1'($urandom_range(0, 1)), 32'($urandom)};
          data_err_i = ($urandom_range(0, 7) == 0);
        end else lat--;
      end
      data_gnt_i = ($urandom_range(0, 2) != 0);
      if (cg) cif.core_req_i = 0;
      if (!cif.core_req_i && $urandom_range(0, 3) == 0) begin
        set_core(1'($urandom_range(0, 1)), 4'($urandom), {$urandom, 2'b00} >> 2 << 2,
                 {1'($urandom_range(0, 1)), 32'($urandom)});
        cif.core_is_cap_i = 1'($urandom_range(0, 1));
      end
      if (dn) begin
        stkz_req_i = 0; stkz_abort_i = 0; saddr += 4; stkz_addr_i = saddr;
      end
      if (!stkz_req_i && $urandom_range(0, 2) == 0) begin
        stkz_req_i = 1; stkz_is_cap_i = 1'($urandom_range(0, 1));
        stkz_abort_i = ($urandom_range(0, 7) == 0);
      end else if (stkz_req_i && !stkz_abort_i && $urandom_range(0, 15) == 0) begin
        stkz_abort_i = 1;
      end
    end
    smp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
